// File: rtl/mdio_master_param.sv
// mdio_master_param: parametrised MDIO management master (Clause 22, optional Clause 45 ST),
// generating MDC from clk and serialising one preamble + 32-bit frame per start request.
// Revision: 1.0
`default_nettype none

module mdio_master_param #(
    parameter int DIV_HALF = 1,
    parameter int PRE_LEN  = 32,
    parameter bit C45_EN   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        PRE_SUP,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        DONE,
    output logic        BUSY,
    output logic        ERR
);

    localparam int            HW       = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [HW-1:0] HALF_MAX = HW'(DIV_HALF - 1);
    localparam logic [5:0]    PRE_LAST = 6'(PRE_LEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]    state;
    logic [HW-1:0] half_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   tx_shift;
    logic [15:0]   rd_shift;
    logic          is_rd;
    logic          pre_sup_q;
    logic          pending;
    logic          ta_bad;
    logic          st_ok;

    assign st_ok = (T_DATA[31:30] == 2'b01) || (C45_EN && (T_DATA[31:30] == 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rd_shift  <= '0;
            is_rd     <= 1'b0;
            pre_sup_q <= 1'b0;
            pending   <= 1'b0;
            ta_bad    <= 1'b0;
            MDC       <= 1'b0;
            MDIO_OUT  <= 1'b1;
            MDIO_OE   <= 1'b0;
            RD_DATA   <= '0;
            DATA_RDY  <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            DONE     <= 1'b0;
            DATA_RDY <= 1'b0;
            ERR      <= 1'b0;
            case (state)
                S_IDLE: begin
                    MDC      <= 1'b0;
                    MDIO_OE  <= 1'b0;
                    MDIO_OUT <= 1'b1;
                    // Command is latched one cycle before the first bit starts.
                    if (pending) begin
                        pending  <= 1'b0;
                        BUSY     <= 1'b1;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        MDIO_OE  <= 1'b1;
                        if (pre_sup_q) begin
                            state    <= S_HDR;
                            MDIO_OUT <= tx_shift[31];
                        end else begin
                            state    <= S_PRE;
                        end
                    end else if (MDIO_START) begin
                        if (st_ok) begin
                            pending   <= 1'b1;
                            tx_shift  <= T_DATA;
                            is_rd     <= T_DATA[29];
                            pre_sup_q <= PRE_SUP;
                            ta_bad    <= 1'b0;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (half_cnt != HALF_MAX) begin
                        half_cnt <= half_cnt + HW'(1);
                    end else begin
                        half_cnt <= '0;
                        if (!MDC) begin
                            MDC <= 1'b1;
                            if (is_rd && (state == S_TA) && (bit_cnt == 6'd1) && MDIO_IN) begin
                                ta_bad <= 1'b1;
                            end
                            if (is_rd && (state == S_DATA)) begin
                                rd_shift <= {rd_shift[14:0], MDIO_IN};
                            end
                        end else begin
                            // End of a bit: pick the next bit and drive it as MDC falls.
                            MDC     <= 1'b0;
                            bit_cnt <= bit_cnt + 6'd1;
                            case (state)
                                S_PRE: begin
                                    if (bit_cnt == PRE_LAST) begin
                                        state    <= S_HDR;
                                        bit_cnt  <= '0;
                                        MDIO_OUT <= tx_shift[31];
                                    end else begin
                                        MDIO_OUT <= 1'b1;
                                    end
                                end
                                S_HDR: begin
                                    if (bit_cnt == 6'd13) begin
                                        // Skip the host TA field so write data sits at the top.
                                        tx_shift <= {tx_shift[28:0], 3'b000};
                                        state    <= S_TA;
                                        bit_cnt  <= '0;
                                        MDIO_OUT <= 1'b1;
                                        MDIO_OE  <= ~is_rd;
                                    end else begin
                                        tx_shift <= {tx_shift[30:0], 1'b0};
                                        MDIO_OUT <= tx_shift[30];
                                    end
                                end
                                S_TA: begin
                                    if (bit_cnt == 6'd1) begin
                                        state    <= S_DATA;
                                        bit_cnt  <= '0;
                                        MDIO_OUT <= is_rd ? 1'b1 : tx_shift[31];
                                        MDIO_OE  <= ~is_rd;
                                    end else begin
                                        MDIO_OUT <= is_rd;
                                    end
                                end
                                default: begin
                                    tx_shift <= {tx_shift[30:0], 1'b0};
                                    if (bit_cnt == 6'd15) begin
                                        state    <= S_FIN;
                                        bit_cnt  <= '0;
                                        BUSY     <= 1'b0;
                                        DONE     <= 1'b1;
                                        MDIO_OE  <= 1'b0;
                                        MDIO_OUT <= 1'b1;
                                        if (is_rd) begin
                                            RD_DATA  <= rd_shift;
                                            DATA_RDY <= 1'b1;
                                            ERR      <= ta_bad;
                                        end
                                    end else begin
                                        MDIO_OUT <= is_rd ? 1'b1 : tx_shift[30];
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
